// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the LegV8 PC sequencer: states, PS selects,
// branch opcode match values and condition codes.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_UPDATE = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      BR_NONE   = 3'd0,
      BR_UNCOND = 3'd1,
      BR_CBZ    = 3'd2,
      BR_CBNZ   = 3'd3,
      BR_COND   = 3'd4
   } br_class_t;

   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_REL  = 2'b10;
   localparam logic [1:0] PS_REL4 = 2'b11;

   localparam logic [5:0]  OP_B     = 6'b000101;
   localparam logic [5:0]  OP_BL    = 6'b100101;
   localparam logic [7:0]  OP_CBZ   = 8'b10110100;
   localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
   localparam logic [7:0]  OP_BCOND = 8'b01010100;
   localparam logic [10:0] OP_HLT   = 11'h6A2;

   localparam logic [3:0] CC_EQ = 4'h0;
   localparam logic [3:0] CC_NE = 4'h1;
   localparam logic [3:0] CC_HS = 4'h2;
   localparam logic [3:0] CC_LO = 4'h3;
   localparam logic [3:0] CC_MI = 4'h4;
   localparam logic [3:0] CC_PL = 4'h5;
   localparam logic [3:0] CC_VS = 4'h6;
   localparam logic [3:0] CC_VC = 4'h7;
   localparam logic [3:0] CC_HI = 4'h8;
   localparam logic [3:0] CC_LS = 4'h9;
   localparam logic [3:0] CC_GE = 4'hA;
   localparam logic [3:0] CC_LT = 4'hB;
   localparam logic [3:0] CC_GT = 4'hC;
   localparam logic [3:0] CC_LE = 4'hD;
   localparam logic [3:0] CC_AL = 4'hE;
   localparam logic [3:0] CC_NV = 4'hF;

   // B/BL are matched on 6 opcode bits, the compare/conditional forms on 8.
   function automatic br_class_t decode_class(input logic [31:0] ir);
      br_class_t cls;
      if ((ir[31:26] == OP_B) || (ir[31:26] == OP_BL)) begin
         cls = BR_UNCOND;
      end else if (ir[31:24] == OP_CBZ) begin
         cls = BR_CBZ;
      end else if (ir[31:24] == OP_CBNZ) begin
         cls = BR_CBNZ;
      end else if (ir[31:24] == OP_BCOND) begin
         cls = BR_COND;
      end else begin
         cls = BR_NONE;
      end
      return cls;
   endfunction

endpackage

// File: rtl/pc_sequencer_branch_cond_eval.sv
// Evaluates a LegV8 4-bit condition code against {N,Z,C,V} status flags.
module branch_cond_eval
   import pc_seq_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       taken
);

   logic n, z, c, v;

   assign n = flags[3];
   assign z = flags[2];
   assign c = flags[1];
   assign v = flags[0];

   always_comb begin
      taken = 1'b0;
      case (cond)
         CC_EQ:   taken = z;
         CC_NE:   taken = !z;
         CC_HS:   taken = c;
         CC_LO:   taken = !c;
         CC_MI:   taken = n;
         CC_PL:   taken = !n;
         CC_VS:   taken = v;
         CC_VC:   taken = !v;
         CC_HI:   taken = c & !z;
         CC_LS:   taken = !(c & !z);
         CC_GE:   taken = (n == v);
         CC_LT:   taken = (n != v);
         CC_GT:   taken = !z & (n == v);
         CC_LE:   taken = !(!z & (n == v));
         CC_AL:   taken = 1'b1;
         CC_NV:   taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute/update controller that drives the ProgramCounter
// select and offset, committing exactly one PC update per instruction.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int          PC_WIDTH    = 64,
   parameter int          INSTR_WIDTH = 32,
   parameter logic [10:0] HALT_OPCODE = OP_HLT
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   run,
   output logic                   imem_req,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic                   exec_done,
   input  logic                   rt_zero,
   input  logic [3:0]             flags,
   output logic [INSTR_WIDTH-1:0] ir,
   output logic [1:0]             PS,
   output logic [PC_WIDTH-1:0]    pc_in,
   output logic                   halt
);

   localparam logic [PC_WIDTH-1:0] ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

   state_t                state;
   br_class_t             br_class;
   logic                  cond_taken;
   logic                  taken;
   logic [PC_WIDTH-1:0]   offset;

   branch_cond_eval u_cond (
      .cond  (ir[3:0]),
      .flags (flags),
      .taken (cond_taken)
   );

   // The PC block adds 4 before scaling `in`, so subtract one word from imm.
   always_comb begin
      offset = {PC_WIDTH{1'b0}};
      if ((ir[31:26] == OP_B) || (ir[31:26] == OP_BL)) begin
         offset = {{(PC_WIDTH-26){ir[25]}}, ir[25:0]} - ONE;
      end else begin
         offset = {{(PC_WIDTH-19){ir[23]}}, ir[23:5]} - ONE;
      end
   end

   always_comb begin
      taken = 1'b0;
      case (br_class)
         BR_UNCOND: taken = 1'b1;
         BR_CBZ:    taken = rt_zero;
         BR_CBNZ:   taken = !rt_zero;
         BR_COND:   taken = cond_taken;
         BR_NONE:   taken = 1'b0;
         default:   taken = 1'b0;
      endcase
   end

   // Main sequencer: all outputs are registered and follow the state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         br_class <= BR_NONE;
         imem_req <= 1'b0;
         ir       <= {INSTR_WIDTH{1'b0}};
         PS       <= PS_HOLD;
         pc_in    <= {PC_WIDTH{1'b0}};
         halt     <= 1'b0;
      end else begin
         PS <= PS_HOLD;
         case (state)
            ST_IDLE: begin
               if (run) begin
                  state    <= ST_FETCH;
                  imem_req <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  ir       <= instr;
                  imem_req <= 1'b0;
                  state    <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (ir[31:21] == HALT_OPCODE) begin
                  state <= ST_HALT;
                  halt  <= 1'b1;
               end else begin
                  br_class <= decode_class(ir);
                  pc_in    <= offset;
                  state    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (exec_done) begin
                  PS    <= taken ? PS_REL4 : PS_INC;
                  state <= ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               if (run) begin
                  state    <= ST_FETCH;
                  imem_req <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_HALT: begin
               halt     <= 1'b1;
               imem_req <= 1'b0;
            end
            default: begin
               state    <= ST_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer driving a behavioural ProgramCounter;
// expectations come from LegV8 branch semantics (target = PC + imm*4).
module tb_pc_sequencer;

   logic        clock;
   logic        reset;
   logic        run;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] instr;
   logic        exec_done;
   logic        rt_zero;
   logic [3:0]  flags;
   logic [31:0] ir;
   logic [1:0]  PS;
   logic [63:0] pc_in;
   logic        halt;

   logic [63:0] pc_model;
   logic [63:0] ref_pc;
   logic [63:0] exp_pc;
   logic        pc_pending;
   int          n_checks;
   int          n_fail;

   typedef struct {
      logic [1:0]  ps;
      logic [63:0] pin;
      logic        chk_pin;
      logic [63:0] pc_after;
   } exp_t;

   exp_t sb[$];

   pc_sequencer dut (
      .clock     (clock),
      .reset     (reset),
      .run       (run),
      .imem_req  (imem_req),
      .imem_ack  (imem_ack),
      .instr     (instr),
      .exec_done (exec_done),
      .rt_zero   (rt_zero),
      .flags     (flags),
      .ir        (ir),
      .PS        (PS),
      .pc_in     (pc_in),
      .halt      (halt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ProgramCounter stand-in: 00 hold, 01 PC+4, 10 PC+4+in, 11 PC+4+in*4.
   always @(posedge clock or posedge reset) begin
      if (reset) pc_model <= 64'd0;
      else begin
         case (PS)
            2'b01:   pc_model <= pc_model + 64'd4;
            2'b10:   pc_model <= pc_model + 64'd4 + pc_in;
            2'b11:   pc_model <= pc_model + 64'd4 + (pc_in << 2);
            default: pc_model <= pc_model;
         endcase
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cf;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cf && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b1;
      return c[0] ? !base : base;
   endfunction

   // LegV8 semantics: which branches are taken, and the word offset they use.
   task automatic ref_branch(input logic [31:0] ins, input logic rz, input logic [3:0] fl,
                             output logic tk, output logic signed [63:0] imm);
      logic signed [63:0] i26, i19;
      i26 = $signed(ins[25:0]);
      i19 = $signed(ins[23:5]);
      if (ins[31:26] == 6'b000101 || ins[31:26] == 6'b100101) begin
         tk = 1'b1; imm = i26;
      end else begin
         imm = i19;
         case (ins[31:24])
            8'hB4:   tk = rz;
            8'hB5:   tk = !rz;
            8'h54:   tk = cond_holds(ins[3:0], fl);
            default: tk = 1'b0;
         endcase
      end
   endtask

   task automatic wait_req(input string name);
      int guard = 0;
      while (imem_req !== 1'b1 && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      check(name, imem_req, 1'b1);
   endtask

   task automatic run_instr(input logic [31:0] ins, input logic rz, input logic [3:0] fl,
                            input int ack_dly, input int exe_dly, input logic drop_run);
      exp_t e;
      logic tk;
      logic signed [63:0] imm;
      wait_req("fetch_req");
      repeat (ack_dly) @(negedge clock);
      ref_branch(ins, rz, fl, tk, imm);
      e.ps       = tk ? 2'b11 : 2'b01;
      e.pin      = imm - 64'sd1;
      e.chk_pin  = tk;
      e.pc_after = tk ? ref_pc + (imm * 64'sd4) : ref_pc + 64'd4;
      ref_pc     = e.pc_after;
      sb.push_back(e);
      imem_ack = 1'b1;
      instr    = ins;
      @(negedge clock);
      imem_ack = 1'b0;
      instr    = $urandom;
      @(negedge clock);
      check("ir_latched", ir, ins);
      repeat (exe_dly - 1) @(negedge clock);
      exec_done = 1'b1;
      rt_zero   = rz;
      flags     = fl;
      if (drop_run) run = 1'b0;
      @(negedge clock);
      exec_done = 1'b0;
      rt_zero   = $urandom_range(0, 1);
      flags     = 4'($urandom);
      #1;
      check("update_seen", sb.size(), 0);
      if (drop_run) begin
         @(negedge clock);
         @(negedge clock);
         check("idle_no_req", imem_req, 1'b0);
         run = 1'b1;
      end
   endtask

   // Monitor: every nonzero PS must match the next scoreboard entry.
   always @(negedge clock) begin
      exp_t e;
      if (pc_pending) begin
         check("pc_after", pc_model, exp_pc);
         pc_pending = 1'b0;
      end
      if (!reset && PS !== 2'b00) begin
         if (sb.size() == 0) begin
            check("unexpected_ps", PS, 2'b00);
         end else begin
            e = sb.pop_front();
            check("ps", PS, e.ps);
            if (e.chk_pin) check("pc_in", pc_in, e.pin);
            exp_pc     = e.pc_after;
            pc_pending = 1'b1;
         end
      end
   end

   initial begin
      logic [31:0] tmp, ins;
      logic [63:0] pc_save;
      n_checks   = 0;
      n_fail     = 0;
      pc_pending = 1'b0;
      ref_pc     = 64'd0;
      reset      = 1'b0;
      run        = 1'b0;
      imem_ack   = 1'b0;
      instr      = 32'd0;
      exec_done  = 1'b0;
      rt_zero    = 1'b0;
      flags      = 4'd0;
      #1 reset = 1'b1;
      #1;
      check("rst_imem_req", imem_req, 1'b0);
      check("rst_ir", ir, 32'd0);
      check("rst_ps", PS, 2'b00);
      check("rst_pc_in", pc_in, 64'd0);
      check("rst_halt", halt, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      run   = 1'b1;

      run_instr(32'h8B020020, 1'b0, 4'b0000, 2, 3, 1'b0);
      run_instr(32'h14000003, 1'b0, 4'b0000, 0, 1, 1'b0);
      run_instr(32'hB4FFFFC0, 1'b1, 4'b0000, 1, 2, 1'b0);
      run_instr(32'hB4FFFFC0, 1'b0, 4'b0000, 0, 1, 1'b1);
      run_instr(32'h54000040, 1'b0, 4'b0100, 3, 1, 1'b0);
      run_instr(32'h54000040, 1'b0, 4'b0000, 0, 2, 1'b0);
      run_instr(32'h5400004A, 1'b0, 4'b1000, 1, 1, 1'b0);

      for (int k = 0; k < 60; k++) begin
         tmp = $urandom;
         case ($urandom_range(0, 5))
            0:       ins = {6'b000101, tmp[25:0]};
            1:       ins = {6'b100101, tmp[25:0]};
            2:       ins = {8'hB4, tmp[23:0]};
            3:       ins = {8'hB5, tmp[23:0]};
            4:       ins = {8'h54, tmp[23:0]};
            default: ins = tmp;
         endcase
         if (ins[31:21] == 11'h6A2) ins[31] = 1'b0;
         run_instr(ins, 1'($urandom_range(0, 1)), 4'($urandom),
                   $urandom_range(0, 3), $urandom_range(1, 4), ($urandom_range(0, 4) == 0));
      end

      wait_req("pre_reset_req");
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_imem_req", imem_req, 1'b0);
      check("mid_rst_ps", PS, 2'b00);
      check("mid_rst_halt", halt, 1'b0);
      check("mid_rst_ir", ir, 32'd0);
      check("mid_rst_pc_in", pc_in, 64'd0);
      @(negedge clock);
      reset  = 1'b0;
      ref_pc = 64'd0;
      wait_req("restart_req");

      imem_ack = 1'b1;
      instr    = 32'hD4400000;
      @(negedge clock);
      imem_ack = 1'b0;
      check("halt_in_decode", halt, 1'b0);
      pc_save = pc_model;
      @(negedge clock);
      check("halt_set", halt, 1'b1);
      for (int k = 0; k < 20; k++) begin
         check("halt_ps", PS, 2'b00);
         check("halt_req", imem_req, 1'b0);
         check("halt_hold", halt, 1'b1);
         @(negedge clock);
      end
      check("halt_pc", pc_model, pc_save);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle fetch/branch controller that sequences the LegV8 ProgramCounter block.
- Drives the PC block's 2-bit PS select and its 64-bit `in` offset.
- Runs a fetch handshake with instruction memory and latches the instruction.
- Decodes unconditional and conditional branches; resolves CBZ/CBNZ and B.cond against datapath status.
- Waits for the datapath to finish execute, then commits exactly one PC update per instruction.
- Sits between instruction memory, the datapath and ProgramCounter.

Parameters:
- PC_WIDTH, 64, width of `pc_in`. Matches ProgramCounter.
- INSTR_WIDTH, 32, instruction width.
- HALT_OPCODE, 11'h6A2, instr[31:21] value that halts the sequencer (HLT).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  start/continue request.
- imem_req  out  1  fetch request to instruction memory.
- imem_ack  in  1  instruction memory has `instr` valid this cycle.
- instr  in  32  instruction word.
- exec_done  in  1  datapath has completed execute for the current `ir`.
- rt_zero  in  1  Rt register == 0; valid when exec_done = 1.
- flags  in  4  {N,Z,C,V}; valid when exec_done = 1.
- ir  out  32  latched instruction, held until the next fetch completes.
- PS  out  2  ProgramCounter select: 00 hold, 01 PC+4, 10 PC+4+in, 11 PC+4+in*4.
- pc_in  out  64  offset to the ProgramCounter `in` port.
- halt  out  1  sequencer halted.

Behaviour:
- Clock is `clock`. Reset is `reset`, asynchronous and active-high.
- Reset values: state IDLE; imem_req 0; ir 0; PS 00; pc_in 0; halt 0. Reset takes effect immediately (not at the next edge) from any state, including mid-fetch.
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
- IDLE: if run = 1, go to FETCH.
- FETCH: imem_req = 1, held until imem_ack = 1. On ack, latch ir <= instr and go to DECODE. imem_ack outside FETCH is ignored.
- DECODE (1 cycle): if ir[31:21] == HALT_OPCODE, go to HALT. Otherwise compute the branch class and pc_in, then go to EXEC.
- EXEC: wait for exec_done = 1. In that cycle, register taken = f(class, rt_zero, flags), then go to UPDATE.
- UPDATE (exactly 1 cycle): PS = 11 if taken, else 01. Next state is FETCH if run = 1, else IDLE.
- PS is 00 in every state except UPDATE, so the PC changes exactly once per instruction.
- Branch classes, decoded from ir:
  - B: [31:26] = 000101. Always taken.
  - BL: [31:26] = 100101. Always taken (link is handled by the datapath).
  - CBZ: [31:24] = 10110100. Taken if rt_zero.
  - CBNZ: [31:24] = 10110101. Taken if !rt_zero.
  - B.cond: [31:24] = 01010100. Taken per cond = ir[3:0].
  - Anything else: not taken.
- Offset arithmetic: LegV8 targets are PC + imm*4, but the PC block computes PC+4+in*4. Therefore pc_in = sign_extend_64(imm) - 1.
  - imm is imm26 = ir[25:0] for B/BL, and imm19 = ir[23:5] for the others.
  - Wraps modulo 2^64.
  - For not-taken instructions pc_in is still driven but is don't-care.
- Condition codes:
  - EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V; GT !Z&(N==V); LE !(!Z&(N==V)).
  - AL (1110) and 1111: always taken.
- HALT: halt = 1, PS = 00, imem_req = 0. Exits only on reset. run is ignored.
- run = 0 never aborts an instruction in flight; it is sampled only in IDLE and UPDATE.
- exec_done arriving in the same cycle the state enters EXEC is accepted; minimum EXEC length is 1 cycle.
- Minimum instruction latency (ack in first FETCH cycle, exec_done in first EXEC cycle) is 4 cycles: FETCH, DECODE, EXEC, UPDATE.

Decomposition:
- Shared package `pc_seq_pkg` holds:
  - the state enum;
  - PS encodings (PS_HOLD, PS_INC, PS_REL, PS_REL4);
  - opcode match constants (OP_B, OP_BL, OP_CBZ, OP_CBNZ, OP_BCOND, OP_HLT);
  - the 4-bit condition code constants.
- One combinational sub-module, `branch_cond_eval` (cond[3:0], flags[3:0] -> taken), reused later by the datapath.

Test Plan:
Bench instantiates pc_sequencer driving a real ProgramCounter; PC starts at 0.
- Reset, run = 1, instr 0x8B020020 (ADD), ack after 2 FETCH cycles, exec_done after 3 EXEC cycles -> one UPDATE cycle with PS = 01, PC 0 -> 4; PS = 00 in all other cycles.
- instr 0x14000003 (B +3) from PC = 4 -> pc_in = 2, PS = 11 for 1 cycle, PC -> 16.
- instr 0xB4FFFFC0 (CBZ imm19 = -2) from PC = 16:
  - rt_zero = 1 -> pc_in = 64'hFFFF_FFFF_FFFF_FFFD, PS = 11, PC -> 8.
  - Repeat with rt_zero = 0 -> PS = 01, PC -> 12.
- instr 0x54000040 (B.EQ +2):
  - flags Z = 1 -> pc_in = 1, PS = 11, PC += 8.
  - flags Z = 0 -> PS = 01.
  - B.GE (cond A) with N = 1, V = 0 -> PS = 01.
- instr 0xD4400000 (HLT) -> halt = 1 from the cycle after DECODE; PS = 00 and imem_req = 0 for 20 cycles with run = 1; PC unchanged.
- Assert reset mid-FETCH while imem_req = 1 -> imem_req, PS, halt, ir and pc_in are all 0 before the next clock edge; after release with run = 1, FETCH restarts.
